mp3_frame_sync: RTL and testbench
=================================

Name: mp3_frame_sync

Overview:
- Downstream consumer of the BRAM byte feeder in the MP3 parser path.
- Accepts a raw MP3 byte stream on a valid-qualified 8-bit bus and hunts for MPEG-1 Layer III frame sync.
- Decodes the 4-byte frame header and computes the frame length in bytes.
- Forwards the frame's payload bytes with first/last markers to the side-info/main-data stage.

Parameters:
- PASS_HEADER, 0: 1 forwards the 4 header bytes on the output stream; 0 forwards only post-header bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- axiid  in  8  input byte
- axiiv  in  1  input byte valid; any cycle, back-to-back or gapped
- axiod  out  8  forwarded byte
- axiov  out  1  forwarded byte valid
- axiofirst  out  1  with axiov: first forwarded byte of a frame
- axiolast  out  1  with axiov: last byte of a frame
- hdr_valid  out  1  one-cycle pulse: header decoded, fields stable until next pulse
- hdr_bitrate_idx  out  4  header bitrate index
- hdr_sr_idx  out  2  sample-rate index
- hdr_padding  out  1  padding bit
- hdr_crc  out  1  1 = CRC present (protection bit == 0)
- hdr_mode  out  2  channel mode
- hdr_mode_ext  out  2  mode extension
- frame_len  out  11  total frame bytes including header
- hdr_err  out  1  one-cycle pulse: sync found but header invalid
- frame_count  out  16  valid headers since reset; wraps at 65535->0
- locked  out  1  high while inside a valid frame (HDR4 accepted through last byte)

Behaviour:
- Reset: all outputs 0; state HUNT; header field registers 0; frame_count 0. rst mid-frame aborts immediately, with no axiolast.
- Only cycles with axiiv=1 advance state; idle cycles hold everything. Pulse outputs are low on all cycles not described below.
- All outputs are registered. A forwarded byte appears on axiod/axiov exactly 1 cycle after its input cycle.
- States: HUNT, SYNC2, HDR3, HDR4, PAYLOAD.
  - HUNT: byte==0xFF -> SYNC2; else stay.
  - SYNC2: byte[7:1]==7'b1111101 (sync, version 11, layer 01) -> latch hdr_crc=~byte[0], go HDR3. byte==0xFF -> stay SYNC2. Otherwise -> HUNT.
  - HDR3: latch bitrate=byte[7:4], sr=byte[3:2], pad=byte[1].
    - bitrate==0 (free format), bitrate==15, or sr==3 -> hdr_err pulse next cycle, go HUNT.
    - Otherwise -> HDR4.
  - HDR4: latch mode=byte[7:6], mode_ext=byte[5:4].
    - Next cycle: hdr_valid=1, frame_len valid, frame_count+1, locked=1.
    - Load remaining = frame_len-4; go PAYLOAD.
  - PAYLOAD: forward each byte and decrement remaining. The byte taking remaining to 0 is forwarded with axiolast=1, then state goes HUNT and locked=0.
- frame_len = floor(144000*kbps/Hz) + pad, from a lookup table.
  - kbps by index 1..14: 32,40,48,56,64,80,96,112,128,160,192,224,256,320.
  - Hz by index 0..2: 44100, 48000, 32000.
  - Range 96..1441, so 11 bits suffice. No divider in RTL.
- PASS_HEADER=1:
  - All four header bytes are forwarded, SYNC2/HDR3 bytes delayed in a 3-byte holding register until HDR4 validates.
  - Header bytes are emitted on consecutive cycles starting the cycle after HDR4 acceptance; axiofirst is on the 0xFF byte.
  - Input bytes arriving during that drain are queued in the holding register, so input order is preserved.
  - Bytes of rejected headers are discarded, never forwarded.
- PASS_HEADER=0: axiofirst is on the first PAYLOAD byte. CRC bytes, if present, are ordinary payload.
- No resync look-ahead: the byte after axiolast is evaluated in HUNT.

Decomposition:
- Package mp3_pkg:
  - state enum sync_state_t;
  - header struct mp3_hdr_t (bitrate_idx, sr_idx, padding, crc, mode, mode_ext);
  - constants SYNC_BYTE=8'hFF and SYNC2_MASK pattern 7'b1111101;
  - the 15x3 frame-length table as a constant array.
- Sub-module mp3_frame_len_lut: combinational (bitrate_idx, sr_idx, padding) -> frame_len[10:0], indexing the package table.

Test Plan:
- FF FB 90 64 then 413 bytes, gapped 8 idle cycles:
  - hdr_valid once; bitrate 9, sr 0, pad 0, mode 01, mode_ext 10, crc 0, frame_len 417;
  - 413 axiov, axiofirst on byte 1, axiolast on byte 413; frame_count=1.
- FF FB 92 64 back-to-back, PASS_HEADER=1: frame_len 418; 418 bytes out, first=0xFF with axiofirst; two such frames back-to-back -> frame_count=2, order preserved.
- Table corners:
  - header3 0xE8 -> 1440; 0xEA -> 1441;
  - 0x14 (br 1, sr 1) -> 96; check 92 payload bytes.
- Invalid headers:
  - header3 0x00 -> hdr_err pulse, no hdr_valid, no axiov;
  - 0xF0 -> hdr_err;
  - 0x9C (sr 3) -> hdr_err;
  - a following valid header still decodes.
- Sync hunting:
  - 00 FF FF FF FB 90 64 -> locks correctly;
  - FF FA (crc) -> hdr_crc=1;
  - FF E3 -> back to HUNT, no hdr_err.
- Reset at payload byte 200 of a 417-byte frame: all outputs 0 the next cycle, no axiolast; a fresh header afterwards decodes with frame_count=1.

Source files
------------

// File: rtl/mp3_pkg.sv
// Shared types and constants for the MP3 frame-sync stage: FSM states,
// decoded header fields and the frame-length table.
package mp3_pkg;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_SYNC2   = 3'd1,
      ST_HDR3    = 3'd2,
      ST_HDR4    = 3'd3,
      ST_PAYLOAD = 3'd4
   } sync_state_t;

   typedef struct packed {
      logic [3:0] bitrate_idx;
      logic [1:0] sr_idx;
      logic       padding;
      logic       crc;
      logic [1:0] mode;
      logic [1:0] mode_ext;
   } mp3_hdr_t;

   localparam logic [7:0] SYNC_BYTE  = 8'hFF;
   localparam logic [6:0] SYNC2_MASK = 7'b1111101;

   // floor(144000*kbps/Hz); columns are 44.1k, 48k, 32k; row 0 is free format
   localparam logic [10:0] FRAME_LEN_TBL [0:14][0:2] = '{
      '{11'd0,    11'd0,   11'd0},
      '{11'd104,  11'd96,  11'd144},
      '{11'd130,  11'd120, 11'd180},
      '{11'd156,  11'd144, 11'd216},
      '{11'd182,  11'd168, 11'd252},
      '{11'd208,  11'd192, 11'd288},
      '{11'd261,  11'd240, 11'd360},
      '{11'd313,  11'd288, 11'd432},
      '{11'd365,  11'd336, 11'd504},
      '{11'd417,  11'd384, 11'd576},
      '{11'd522,  11'd480, 11'd720},
      '{11'd626,  11'd576, 11'd864},
      '{11'd731,  11'd672, 11'd1008},
      '{11'd835,  11'd768, 11'd1152},
      '{11'd1044, 11'd960, 11'd1440}
   };

endpackage

// File: rtl/mp3_frame_len_lut.sv
// Combinational frame length lookup: table value plus the padding byte.
module mp3_frame_len_lut
   import mp3_pkg::*;
(
   input  logic [3:0]  bitrate_idx,
   input  logic [1:0]  sr_idx,
   input  logic        padding,
   output logic [10:0] frame_len
);

   always_comb begin
      frame_len = '0;
      if (bitrate_idx != 4'd15 && sr_idx != 2'd3)
         frame_len = FRAME_LEN_TBL[bitrate_idx][sr_idx] + {10'd0, padding};
   end

endmodule

// File: rtl/mp3_frame_sync.sv
// MPEG-1 Layer III frame sync: hunts for the header, decodes it, and forwards
// the frame bytes with first/last markers.
module mp3_frame_sync
   import mp3_pkg::*;
#(
   parameter bit PASS_HEADER = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  axiid,
   input  logic        axiiv,
   output logic [7:0]  axiod,
   output logic        axiov,
   output logic        axiofirst,
   output logic        axiolast,
   output logic        hdr_valid,
   output logic [3:0]  hdr_bitrate_idx,
   output logic [1:0]  hdr_sr_idx,
   output logic        hdr_padding,
   output logic        hdr_crc,
   output logic [1:0]  hdr_mode,
   output logic [1:0]  hdr_mode_ext,
   output logic [10:0] frame_len,
   output logic        hdr_err,
   output logic [15:0] frame_count,
   output logic        locked
);

   sync_state_t state;
   mp3_hdr_t    work, hdr, nxt_hdr;
   logic [10:0] remaining, lut_len;
   logic [7:0]  hold1, hold2;
   logic [7:0]  q_data [3];
   logic [7:0]  q_nxt_data [3];
   logic [2:0]  q_last, q_nxt_last;
   logic [1:0]  q_cnt, q_nxt_cnt;
   logic        first_pend;
   logic        fwd, fwd_last, accept, hdr3_bad;
   logic        out_v, out_first, out_last;
   logic [7:0]  out_d;

   mp3_frame_len_lut u_lut (
      .bitrate_idx (work.bitrate_idx),
      .sr_idx      (work.sr_idx),
      .padding     (work.padding),
      .frame_len   (lut_len)
   );

   assign fwd      = axiiv && (state == ST_PAYLOAD);
   assign fwd_last = (remaining == 11'd1);
   assign accept   = axiiv && (state == ST_HDR4);
   assign hdr3_bad = (axiid[7:4] == 4'd0) || (axiid[7:4] == 4'd15) || (axiid[3:2] == 2'd3);

   always_comb begin
      nxt_hdr          = work;
      nxt_hdr.mode     = axiid[7:6];
      nxt_hdr.mode_ext = axiid[5:4];
   end

   // Output byte selection. The queue only fills with PASS_HEADER: the held
   // header bytes drain one per cycle and later input bytes queue behind them.
   always_comb begin
      q_nxt_data = q_data;
      q_nxt_last = q_last;
      q_nxt_cnt  = q_cnt;
      out_v      = 1'b0;
      out_d      = 8'h00;
      out_first  = 1'b0;
      out_last   = 1'b0;
      if (PASS_HEADER && accept) begin
         out_v         = 1'b1;
         out_d         = SYNC_BYTE;
         out_first     = 1'b1;
         q_nxt_data[0] = hold1;
         q_nxt_data[1] = hold2;
         q_nxt_data[2] = axiid;
         q_nxt_last    = 3'b000;
         q_nxt_cnt     = 2'd3;
      end else begin
         if (q_cnt != 2'd0) begin
            out_v         = 1'b1;
            out_d         = q_data[0];
            out_last      = q_last[0];
            q_nxt_data[0] = q_data[1];
            q_nxt_data[1] = q_data[2];
            q_nxt_last    = {1'b0, q_last[2:1]};
            q_nxt_cnt     = q_cnt - 2'd1;
         end
         if (fwd) begin
            if (q_cnt == 2'd0) begin
               out_v     = 1'b1;
               out_d     = axiid;
               out_last  = fwd_last;
               out_first = !PASS_HEADER && first_pend;
            end else begin
               case (q_nxt_cnt)
                  2'd0:    begin q_nxt_data[0] = axiid; q_nxt_last[0] = fwd_last; end
                  2'd1:    begin q_nxt_data[1] = axiid; q_nxt_last[1] = fwd_last; end
                  default: begin q_nxt_data[2] = axiid; q_nxt_last[2] = fwd_last; end
               endcase
               q_nxt_cnt = q_nxt_cnt + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_HUNT;
         work        <= '0;
         hdr         <= '0;
         remaining   <= '0;
         hold1       <= '0;
         hold2       <= '0;
         q_data      <= '{default: 8'h00};
         q_last      <= '0;
         q_cnt       <= '0;
         first_pend  <= 1'b0;
         axiod       <= '0;
         axiov       <= 1'b0;
         axiofirst   <= 1'b0;
         axiolast    <= 1'b0;
         hdr_valid   <= 1'b0;
         hdr_err     <= 1'b0;
         frame_len   <= '0;
         frame_count <= '0;
         locked      <= 1'b0;
      end else begin
         q_data    <= q_nxt_data;
         q_last    <= q_nxt_last;
         q_cnt     <= q_nxt_cnt;
         axiod     <= out_d;
         axiov     <= out_v;
         axiofirst <= out_first;
         axiolast  <= out_last;
         hdr_valid <= 1'b0;
         hdr_err   <= 1'b0;
         if (axiiv) begin
            case (state)
               ST_HUNT: if (axiid == SYNC_BYTE) state <= ST_SYNC2;
               ST_SYNC2: begin
                  if (axiid[7:1] == SYNC2_MASK) begin
                     work.crc <= ~axiid[0];
                     hold1    <= axiid;
                     state    <= ST_HDR3;
                  end else if (axiid != SYNC_BYTE) begin
                     state <= ST_HUNT;
                  end
               end
               ST_HDR3: begin
                  work.bitrate_idx <= axiid[7:4];
                  work.sr_idx      <= axiid[3:2];
                  work.padding     <= axiid[1];
                  hold2            <= axiid;
                  if (hdr3_bad) begin
                     hdr_err <= 1'b1;
                     state   <= ST_HUNT;
                  end else begin
                     state <= ST_HDR4;
                  end
               end
               ST_HDR4: begin
                  hdr         <= nxt_hdr;
                  frame_len   <= lut_len;
                  remaining   <= lut_len - 11'd4;
                  frame_count <= frame_count + 16'd1;
                  hdr_valid   <= 1'b1;
                  locked      <= 1'b1;
                  first_pend  <= 1'b1;
                  state       <= ST_PAYLOAD;
               end
               ST_PAYLOAD: begin
                  remaining  <= remaining - 11'd1;
                  first_pend <= 1'b0;
                  if (fwd_last) begin
                     locked <= 1'b0;
                     state  <= ST_HUNT;
                  end
               end
               default: state <= ST_HUNT;
            endcase
         end
      end
   end

   assign hdr_bitrate_idx = hdr.bitrate_idx;
   assign hdr_sr_idx      = hdr.sr_idx;
   assign hdr_padding     = hdr.padding;
   assign hdr_crc         = hdr.crc;
   assign hdr_mode        = hdr.mode;
   assign hdr_mode_ext    = hdr.mode_ext;

endmodule

// File: tb/tb_mp3_frame_sync.sv
// Directed bench for mp3_frame_sync: one instance without and one with
// header pass-through, driven by the same byte stream.
module tb_mp3_frame_sync;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  axiid = 8'h00;
   logic        axiiv = 1'b0;

   logic [7:0]  d0, d1;
   logic        v0, f0, l0, hv0_o, er0_o, crc0, pad0, lk0;
   logic        v1, f1, l1, hv1_o, er1_o, crc1, pad1, lk1;
   logic [3:0]  br0, br1;
   logic [1:0]  sr0, md0, mx0, sr1, md1, mx1;
   logic [10:0] len0, len1;
   logic [15:0] cnt0, cnt1;

   mp3_frame_sync #(.PASS_HEADER(1'b0)) dut0 (
      .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
      .axiod(d0), .axiov(v0), .axiofirst(f0), .axiolast(l0),
      .hdr_valid(hv0_o), .hdr_bitrate_idx(br0), .hdr_sr_idx(sr0), .hdr_padding(pad0),
      .hdr_crc(crc0), .hdr_mode(md0), .hdr_mode_ext(mx0), .frame_len(len0),
      .hdr_err(er0_o), .frame_count(cnt0), .locked(lk0)
   );

   mp3_frame_sync #(.PASS_HEADER(1'b1)) dut1 (
      .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
      .axiod(d1), .axiov(v1), .axiofirst(f1), .axiolast(l1),
      .hdr_valid(hv1_o), .hdr_bitrate_idx(br1), .hdr_sr_idx(sr1), .hdr_padding(pad1),
      .hdr_crc(crc1), .hdr_mode(md1), .hdr_mode_ext(mx1), .frame_len(len1),
      .hdr_err(er1_o), .frame_count(cnt1), .locked(lk1)
   );

   always #5 clk = ~clk;

   // Captured output streams as {first, last, byte} and pulse counters.
   logic [9:0] mon0[$], mon1[$], exp0[$], exp1[$];
   int hv0 = 0, hv1 = 0, er0 = 0;

   always @(negedge clk) begin
      if (v0) mon0.push_back({f0, l0, d0});
      if (v1) mon1.push_back({f1, l1, d1});
      if (hv0_o) hv0 <= hv0 + 1;
      if (hv1_o) hv1 <= hv1 + 1;
      if (er0_o) er0 <= er0 + 1;
   end

   int checks = 0;
   int errors = 0;
   int b0, b1, hb0, hb1, eb0;

   function automatic logic [7:0] pat(input int i, input int seed);
      return 8'((i * 7 + seed) % 256);
   endfunction

   // -1 when the captured stream from base equals exp, -2 on length mismatch,
   // else the index of the first differing entry.
   function automatic int stream_diff(input logic [9:0] mon[$], input int base, input logic [9:0] exp[$]);
      if (mon.size() - base != exp.size()) return -2;
      for (int k = 0; k < exp.size(); k++)
         if (mon[base + k] !== exp[k]) return k;
      return -1;
   endfunction

   task automatic rebase();
      b0 = mon0.size();
      b1 = mon1.size();
      hb0 = hv0;
      hb1 = hv1;
      eb0 = er0;
      exp0.delete();
      exp1.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      axiiv = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rebase();
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      axiid = b;
      axiiv = 1'b1;
      @(posedge clk);
      #1 axiiv = 1'b0;
      idle(gap);
   endtask

   task automatic send_hdr(input logic [7:0] h2, input logic [7:0] h3, input logic [7:0] h4, input int gap);
      exp1.push_back({2'b10, 8'hFF});
      exp1.push_back({2'b00, h2});
      exp1.push_back({2'b00, h3});
      exp1.push_back({2'b00, h4});
      send_byte(8'hFF, gap);
      send_byte(h2, gap);
      send_byte(h3, gap);
      send_byte(h4, gap);
   endtask

   task automatic send_payload(input int from, input int to, input int n, input int gap, input int seed);
      for (int i = from; i <= to; i++) begin
         logic [7:0] b;
         b = pat(i, seed);
         exp0.push_back({i == 1, i == n, b});
         exp1.push_back({1'b0, i == n, b});
         send_byte(b, gap);
      end
   endtask

   task automatic check_streams(input string tag);
      int r;
      r = stream_diff(mon0, b0, exp0);
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL %s stream0 got_len=%0d want_len=%0d first_bad=%0d", tag, mon0.size() - b0, exp0.size(), r);
      end
      r = stream_diff(mon1, b1, exp1);
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL %s stream1 got_len=%0d want_len=%0d first_bad=%0d", tag, mon1.size() - b1, exp1.size(), r);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({v0, f0, l0, hv0_o, er0_o, lk0} !== 6'b0) begin
         errors++; $display("FAIL reset_flags0 got=%b want=000000", {v0, f0, l0, hv0_o, er0_o, lk0});
      end
      checks++;
      if ({d0, len0, cnt0} !== 35'd0) begin
         errors++; $display("FAIL reset_data0 got=%h want=0", {d0, len0, cnt0});
      end
      checks++;
      if ({br0, sr0, pad0, crc0, md0, mx0} !== 12'd0) begin
         errors++; $display("FAIL reset_fields0 got=%h want=0", {br0, sr0, pad0, crc0, md0, mx0});
      end
      checks++;
      if ({v1, f1, l1, hv1_o, er1_o, lk1, cnt1} !== 22'd0) begin
         errors++; $display("FAIL reset_dut1 got=%h want=0", {v1, f1, l1, hv1_o, er1_o, lk1, cnt1});
      end
      rst = 1'b0;
      rebase();
   endtask

   task automatic test_gapped();
      do_reset();
      send_hdr(8'hFB, 8'h90, 8'h64, 8);
      send_payload(1, 1, 413, 0, 3);
      checks++;
      if ({v0, f0, l0, d0} !== {3'b110, pat(1, 3)}) begin
         errors++; $display("FAIL gapped_first_byte got=%h want=%h", {v0, f0, l0, d0}, {3'b110, pat(1, 3)});
      end
      checks++;
      if (lk0 !== 1'b1) begin
         errors++; $display("FAIL gapped_locked got=%b want=1", lk0);
      end
      idle(8);
      send_payload(2, 413, 413, 8, 3);
      idle(8);
      checks++;
      if (hv0 - hb0 != 1 || er0 - eb0 != 0) begin
         errors++; $display("FAIL gapped_pulses hv=%0d err=%0d want 1 0", hv0 - hb0, er0 - eb0);
      end
      checks++;
      if ({br0, sr0, pad0, crc0, md0, mx0} !== {4'd9, 2'd0, 1'b0, 1'b0, 2'b01, 2'b10}) begin
         errors++; $display("FAIL gapped_fields got=%h want=%h", {br0, sr0, pad0, crc0, md0, mx0},
                            {4'd9, 2'd0, 1'b0, 1'b0, 2'b01, 2'b10});
      end
      checks++;
      if (len0 !== 11'd417) begin
         errors++; $display("FAIL gapped_len got=%0d want=417", len0);
      end
      checks++;
      if (cnt0 !== 16'd1 || lk0 !== 1'b0) begin
         errors++; $display("FAIL gapped_count got=%0d/%b want=1/0", cnt0, lk0);
      end
      check_streams("gapped");
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int f = 0; f < 2; f++) begin
         send_hdr(8'hFB, 8'h92, 8'h64, 0);
         send_payload(1, 414, 414, 0, 5 + f);
      end
      idle(8);
      checks++;
      if (len1 !== 11'd418 || len0 !== 11'd418) begin
         errors++; $display("FAIL b2b_len got=%0d/%0d want=418", len0, len1);
      end
      checks++;
      if (cnt1 !== 16'd2 || cnt0 !== 16'd2 || hv1 - hb1 != 2) begin
         errors++; $display("FAIL b2b_count got=%0d/%0d hv=%0d want=2", cnt0, cnt1, hv1 - hb1);
      end
      check_streams("b2b");
   endtask

   task automatic test_table_corners();
      logic [7:0] h3s [3];
      int lens [3];
      h3s = '{8'hE8, 8'hEA, 8'h14};
      lens = '{1440, 1441, 96};
      for (int k = 0; k < 3; k++) begin
         do_reset();
         send_hdr(8'hFB, h3s[k], 8'h00, 0);
         send_payload(1, lens[k] - 4, lens[k] - 4, 0, k);
         idle(6);
         checks++;
         if (len0 !== 11'(lens[k]) || len1 !== 11'(lens[k])) begin
            errors++; $display("FAIL corner_len_%h got=%0d/%0d want=%0d", h3s[k], len0, len1, lens[k]);
         end
         check_streams("corner");
      end
   endtask

   task automatic test_invalid();
      logic [7:0] bads [3];
      bads = '{8'h00, 8'hF0, 8'h9C};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         send_byte(8'hFF, 0);
         send_byte(8'hFB, 0);
         send_byte(bads[k], 0);
         checks++;
         if ({er0_o, er1_o, hv0_o} !== 3'b110) begin
            errors++; $display("FAIL invalid_err_%h got=%b want=110", bads[k], {er0_o, er1_o, hv0_o});
         end
         send_byte(8'h64, 0);
         send_byte(8'h00, 0);
      end
      idle(4);
      checks++;
      if (er0 - eb0 != 3 || hv0 - hb0 != 0) begin
         errors++; $display("FAIL invalid_pulses err=%0d hv=%0d want 3 0", er0 - eb0, hv0 - hb0);
      end
      checks++;
      if (mon0.size() != b0 || mon1.size() != b1) begin
         errors++; $display("FAIL invalid_no_output got=%0d/%0d want=0", mon0.size() - b0, mon1.size() - b1);
      end
      send_hdr(8'hFB, 8'h14, 8'h00, 0);
      send_payload(1, 92, 92, 0, 9);
      idle(6);
      checks++;
      if (hv0 - hb0 != 1 || len0 !== 11'd96 || cnt0 !== 16'd1) begin
         errors++; $display("FAIL invalid_recover hv=%0d len=%0d cnt=%0d want 1 96 1", hv0 - hb0, len0, cnt0);
      end
      check_streams("recover");
   endtask

   task automatic test_hunt();
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'hFF, 0);
      send_hdr(8'hFB, 8'h90, 8'h64, 0);
      send_payload(1, 413, 413, 0, 11);
      idle(6);
      checks++;
      if (hv0 - hb0 != 1 || len0 !== 11'd417 || crc0 !== 1'b0) begin
         errors++; $display("FAIL hunt_lock hv=%0d len=%0d crc=%b want 1 417 0", hv0 - hb0, len0, crc0);
      end
      send_hdr(8'hFA, 8'h90, 8'h64, 0);
      checks++;
      if ({hv0_o, crc0, crc1} !== 3'b111) begin
         errors++; $display("FAIL hunt_crc got=%b want=111", {hv0_o, crc0, crc1});
      end
      send_payload(1, 413, 413, 0, 12);
      idle(6);
      send_byte(8'hFF, 0);
      send_byte(8'hE3, 0);
      send_byte(8'h90, 0);
      send_byte(8'h64, 0);
      send_byte(8'h00, 0);
      idle(4);
      checks++;
      if (er0 - eb0 != 0 || hv0 - hb0 != 2 || cnt0 !== 16'd2 || lk0 !== 1'b0) begin
         errors++; $display("FAIL hunt_badsync err=%0d hv=%0d cnt=%0d lk=%b want 0 2 2 0",
                            er0 - eb0, hv0 - hb0, cnt0, lk0);
      end
      check_streams("hunt");
   endtask

   task automatic test_reset_mid();
      int nl;
      do_reset();
      send_hdr(8'hFB, 8'h90, 8'h64, 0);
      send_payload(1, 199, 413, 0, 13);
      axiid = pat(200, 13);
      axiiv = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1 axiiv = 1'b0;
      checks++;
      if ({v0, f0, l0, hv0_o, er0_o, lk0, d0, len0, cnt0} !== 41'd0) begin
         errors++; $display("FAIL midreset_dut0 got=%h want=0", {v0, f0, l0, hv0_o, er0_o, lk0, d0, len0, cnt0});
      end
      checks++;
      if ({v1, l1, lk1, len1, cnt1} !== 30'd0) begin
         errors++; $display("FAIL midreset_dut1 got=%h want=0", {v1, l1, lk1, len1, cnt1});
      end
      nl = 0;
      for (int k = b0; k < mon0.size(); k++) if (mon0[k][8]) nl++;
      for (int k = b1; k < mon1.size(); k++) if (mon1[k][8]) nl++;
      checks++;
      if (nl != 0 || mon0.size() - b0 != 199) begin
         errors++; $display("FAIL midreset_nolast lasts=%0d bytes=%0d want 0 199", nl, mon0.size() - b0);
      end
      rst = 1'b0;
      rebase();
      send_hdr(8'hFB, 8'h90, 8'h64, 0);
      send_payload(1, 413, 413, 0, 17);
      idle(6);
      checks++;
      if (cnt0 !== 16'd1 || cnt1 !== 16'd1 || hv0 - hb0 != 1) begin
         errors++; $display("FAIL midreset_fresh cnt=%0d/%0d hv=%0d want 1", cnt0, cnt1, hv0 - hb0);
      end
      check_streams("fresh");
   endtask

   initial begin
      test_reset();
      test_gapped();
      test_back_to_back();
      test_table_corners();
      test_invalid();
      test_hunt();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
